// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array sequencer.
//   W_DEF        default operand/result width
//   ctrl_state_t sequencer state encoding (also exported on dbg_state)
//   ctrl_cnt_w   width of the COMPUTE cycle counter, sized so that the
//                count k_len+N-1 can never wrap
package systolic_pkg;

  localparam int W_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_COMPUTE = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_DONE    = 3'd4
  } ctrl_state_t;

  function automatic int ctrl_cnt_w(input int kw, input int n);
    return kw + $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/systolic_ctrl_skew_line.sv
// skew_line: DEPTH-stage shift register with synchronous zero reset.
// Delays a column's top operand so it meets the row operand after the
// row operand has rippled DEPTH columns across the array.
//   clk, reset : clock and synchronous active-high clear
//   din        : operand entering the line
//   dout       : operand delayed by DEPTH cycles (DEPTH=0 is a wire)
module skew_line #(
  parameter int DEPTH = 0,
  parameter int W     = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_wire
      // Column 0 needs no delay; clk/reset are intentionally unused here.
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ reset;
      assign dout = din;
    end else begin : g_pipe
      logic [DEPTH-1:0][W-1:0] pipe_d;
      logic [DEPTH-1:0][W-1:0] pipe_q;

      always_comb begin
        pipe_d    = pipe_q;
        pipe_d[0] = din;
        for (int s = 1; s < DEPTH; s++) begin
          pipe_d[s] = pipe_q[s-1];
        end
      end

      always_ff @(posedge clk) begin
        if (reset) pipe_q <= '0;
        else       pipe_q <= pipe_d;
      end

      assign dout = pipe_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/systolic_ctrl.sv
// systolic_ctrl: sequencer for an N x N accumulate-and-shift PE array.
// Clears the array, streams k_len operand vectors from the A/B buffers
// (column operands skewed one cycle per column), then drains the array
// one column per beat through a registered valid/ready result port.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   start, k_len        job request (sampled in IDLE only) and inner dimension
//   busy, done          state != IDLE; one-cycle completion pulse
//   op_rd_en, op_addr   operand buffer read strobe / k index (1-cycle latency)
//   a_rdata, b_rdata    A column k (row i at [i*W+:W]), B row k (col j)
//   pe_reset, pe_read   array clear / array shift-out strobe
//   pe_l_d, pe_t_d      left-edge row operands, top column operands
//   pe_res              column-0 accumulator per row
//   res_valid/ready/data/last   result stream, one array column per beat
//   perf_cycles         busy-cycle count of the current job (saturating),
//                       present only when SYSTOLIC_CTRL_PERF_EN is defined
//   dbg_state           current sequencer state
module systolic_ctrl
  import systolic_pkg::*;
#(
  parameter int N  = 4,
  parameter int W  = W_DEF,
  parameter int KW = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [KW-1:0]   k_len,
  output logic            busy,
  output logic            done,
  output logic            op_rd_en,
  output logic [KW-1:0]   op_addr,
  input  logic [N*W-1:0]  a_rdata,
  input  logic [N*W-1:0]  b_rdata,
  output logic            pe_reset,
  output logic            pe_read,
  output logic [N*W-1:0]  pe_l_d,
  output logic [N*W-1:0]  pe_t_d,
  input  logic [N*W-1:0]  pe_res,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [N*W-1:0]  res_data,
  output logic            res_last,
`ifdef SYSTOLIC_CTRL_PERF_EN
  output logic [31:0]     perf_cycles,
`endif
  output logic [2:0]      dbg_state
);

  localparam int CW = ctrl_cnt_w(KW, N);
  localparam int BW = $clog2(N) + 1;

  ctrl_state_t     state_q, state_d;
  logic [KW-1:0]   k_len_q, k_len_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BW-1:0]   beats_q, beats_d;
  logic            op_rd_en_q, op_rd_en_d;
  logic [KW-1:0]   op_addr_q, op_addr_d;
  logic            op_vld_q, op_vld_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pe_reset_q, pe_reset_d;
  logic            res_valid_q, res_valid_d;
  logic            res_last_q, res_last_d;
  logic [N*W-1:0]  res_data_q, res_data_d;
`ifdef SYSTOLIC_CTRL_PERF_EN
  logic [31:0]     perf_q, perf_d;
`endif

  logic            pop;
  logic [N*W-1:0]  t_skew;

  // Result handshake: a beat transfers on a rising edge where res_valid and
  // res_ready are both high. While res_valid is high and res_ready low,
  // res_data/res_last hold. A new column is popped from the array whenever
  // the output register is empty or is being emptied in the same cycle.
  assign pop = (state_q == ST_DRAIN) && (beats_q < BW'(N)) &&
               (!res_valid_q || res_ready);

  always_comb begin
    state_d     = state_q;
    k_len_d     = k_len_q;
    cnt_d       = cnt_q;
    beats_d     = beats_q;
    res_valid_d = res_valid_q;
    res_last_d  = res_last_q;
    res_data_d  = res_data_q;
    // The buffer returns data one cycle after the strobe.
    op_vld_d    = op_rd_en_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          k_len_d = k_len;
          state_d = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        cnt_d   = '0;
        beats_d = '0;
        state_d = ST_COMPUTE;
      end
      ST_COMPUTE: begin
        // N extra cycles let the last operand ripple into column N-1.
        if (cnt_q == CW'(k_len_q) + CW'(N - 1)) begin
          cnt_d   = '0;
          beats_d = '0;
          state_d = ST_DRAIN;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DRAIN: begin
        if (pop) begin
          res_data_d  = pe_res;
          res_valid_d = 1'b1;
          res_last_d  = (beats_q == BW'(N - 1));
          beats_d     = beats_q + BW'(1);
        end else if (res_valid_q && res_ready) begin
          res_valid_d = 1'b0;
          res_last_d  = 1'b0;
          if (res_last_q) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are registered from the next-state view so they line up
    // with the state they describe.
    busy_d     = (state_d != ST_IDLE);
    done_d     = (state_d == ST_DONE);
    pe_reset_d = (state_d == ST_CLEAR);
    op_rd_en_d = (state_d == ST_COMPUTE) && (cnt_d < CW'(k_len_d));
    op_addr_d  = op_rd_en_d ? cnt_d[KW-1:0] : '0;
  end

`ifdef SYSTOLIC_CTRL_PERF_EN
  always_comb begin
    perf_d = perf_q;
    if (state_q == ST_IDLE && start) begin
      perf_d = '0;
    end else if (state_q != ST_IDLE && perf_q != '1) begin
      perf_d = perf_q + 32'd1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      k_len_q     <= '0;
      cnt_q       <= '0;
      beats_q     <= '0;
      op_rd_en_q  <= 1'b0;
      op_addr_q   <= '0;
      op_vld_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pe_reset_q  <= 1'b0;
      res_valid_q <= 1'b0;
      res_last_q  <= 1'b0;
      res_data_q  <= '0;
`ifdef SYSTOLIC_CTRL_PERF_EN
      perf_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      k_len_q     <= k_len_d;
      cnt_q       <= cnt_d;
      beats_q     <= beats_d;
      op_rd_en_q  <= op_rd_en_d;
      op_addr_q   <= op_addr_d;
      op_vld_q    <= op_vld_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pe_reset_q  <= pe_reset_d;
      res_valid_q <= res_valid_d;
      res_last_q  <= res_last_d;
      res_data_q  <= res_data_d;
`ifdef SYSTOLIC_CTRL_PERF_EN
      perf_q      <= perf_d;
`endif
    end
  end

  // Column j's top operand is delayed j cycles to match the one-cycle-per-
  // column horizontal travel of the row operand inside the array.
  generate
    for (genvar j = 0; j < N; j++) begin : g_col
      logic [W-1:0] b_sel;
      assign b_sel = op_vld_q ? b_rdata[j*W +: W] : '0;
      skew_line #(
        .DEPTH(j),
        .W    (W)
      ) u_skew (
        .clk  (clk),
        .reset(reset),
        .din  (b_sel),
        .dout (t_skew[j*W +: W])
      );
    end
  endgenerate

  // Operands are forced to zero outside COMPUTE so idle/drain cycles
  // leave the accumulators untouched.
  assign pe_l_d    = op_vld_q ? a_rdata : '0;
  assign pe_t_d    = (state_q == ST_COMPUTE) ? t_skew : '0;
  assign pe_read   = pop;
  assign pe_reset  = reset | pe_reset_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign op_rd_en  = op_rd_en_q;
  assign op_addr   = op_addr_q;
  assign res_valid = res_valid_q;
  assign res_last  = res_last_q;
  assign res_data  = res_data_q;
  assign dbg_state = state_q;
`ifdef SYSTOLIC_CTRL_PERF_EN
  assign perf_cycles = perf_q;
`endif

endmodule
